// File: rtl/mem_arbiter_pkg.sv
// Purpose : shared types and constants for the three-requester memory arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: requester index constants, default geometry, one-hot grant type,
//           index helpers used by the picker and the completion decode.
package mem_arbiter_pkg;

  localparam int NREQ_FIXED = 3;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 512;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_DISK  = 2'd2;

  typedef logic [NREQ_FIXED-1:0] gnt_t;

  // Index 3 is not a requester; it decodes to an empty grant.
  function automatic gnt_t idx2onehot(input logic [1:0] idx);
    gnt_t oh;
    oh = '0;
    if (idx <= REQ_DISK) oh[idx] = 1'b1;
    return oh;
  endfunction

  // Next requester in round-robin order, wrapping DISK -> FETCH.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    if (idx >= REQ_DISK) nxt = REQ_FETCH;
    else                 nxt = idx + 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Purpose : combinational 3-way round-robin picker.
// Latency : zero cycles, pure combinational.
// Backpressure: none; losing requesters simply see no grant this cycle.
// Ports   : req[2:0] requests, last[1:0] previously granted index;
//           gnt_onehot[2:0] winner one-hot, win[1:0] winner index, any = some request present.
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output gnt_t       gnt_onehot,
  output logic [1:0] win,
  output logic       any
);

  logic [1:0] cand0;
  logic [1:0] cand1;
  logic [1:0] cand2;

  // Search order starts just after the last winner.
  assign cand0 = next_idx(last);
  assign cand1 = next_idx(cand0);
  assign cand2 = next_idx(cand1);

  always_comb begin
    any = 1'b1;
    win = cand0;
    if (req[cand0]) begin
      win = cand0;
    end else if (req[cand1]) begin
      win = cand1;
    end else if (req[cand2]) begin
      win = cand2;
    end else begin
      any = 1'b0;
      win = REQ_FETCH;
    end
    gnt_onehot = any ? idx2onehot(win) : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : round-robin share of a single-port word memory between fetch, data and disk requesters.
// Latency : grant and memory drive same cycle as request; rvalid/err one cycle after the grant.
// Backpressure: a requester without gnt must hold req/we/addr/wdata; one access per clock total.
// Ports   : clock, reset_n (async, active low); req/we/addr/wdata per requester (packed by index);
//           gnt/rvalid/err one-hot per requester, rdata shared; mem_addr/mem_wdata/mem_write
//           drive the memory, mem_rdata returns one cycle after the address.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NREQ   = NREQ_FIXED
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [NREQ-1:0]          err,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_rdata
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  // Round-robin and pending-completion state.
  logic [1:0]        rr_ptr;
  logic              rr_seen;
  logic              pend_valid;
  logic [1:0]        pend_owner;
  logic              pend_err;
  logic              pend_rd;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;

  gnt_t              pick_gnt;
  logic [1:0]        pick_win;
  logic              pick_any;
  logic [1:0]        pick_last;

  // Until the first grant after reset, pretend DISK was last so FETCH is searched first.
  assign pick_last = rr_seen ? rr_ptr : REQ_DISK;

  rr_pick u_rr_pick (
    .req        (req),
    .last       (pick_last),
    .gnt_onehot (pick_gnt),
    .win        (pick_win),
    .any        (pick_any)
  );

  logic              grant_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              in_range;

  // Outputs are forced quiet while reset is asserted, even if requests are present.
  assign grant_vld = reset_n & pick_any;
  assign sel_addr  = addr_a[pick_win];
  assign sel_wdata = wdata_a[pick_win];
  assign sel_we    = we[pick_win];
  assign in_range  = ({1'b0, sel_addr} < DEPTH_L);

  assign gnt       = grant_vld ? pick_gnt : '0;
  assign mem_addr  = grant_vld ? sel_addr  : addr_hold;
  assign mem_wdata = grant_vld ? sel_wdata : wdata_hold;
  // Out-of-range writes never reach the memory.
  assign mem_write = grant_vld & sel_we & in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= REQ_FETCH;
      rr_seen    <= 1'b0;
      pend_valid <= 1'b0;
      pend_owner <= REQ_FETCH;
      pend_err   <= 1'b0;
      pend_rd    <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      pend_valid <= pick_any;
      if (pick_any) begin
        rr_ptr     <= pick_win;
        rr_seen    <= 1'b1;
        pend_owner <= pick_win;
        pend_err   <= ~in_range;
        pend_rd    <= ~sel_we;
        addr_hold  <= sel_addr;
        wdata_hold <= sel_wdata;
      end
    end
  end

  // Completion of last cycle's access; independent of whatever is granted now.
  logic rd_done;
  logic err_done;

  assign rd_done  = pend_valid & pend_rd & ~pend_err;
  assign err_done = pend_valid & pend_err;

  assign rvalid = rd_done  ? idx2onehot(pend_owner) : '0;
  assign err    = err_done ? idx2onehot(pend_owner) : '0;
  assign rdata  = rd_done  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int N     = 3;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, we, gnt, rvalid, err;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_write;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .NREQ(N)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Environment memory: synchronous, one-cycle read latency.
  logic [DW-1:0] ram [1024];
  always @(posedge clock) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Requester-side stimulus state.
  bit            p_req [N];
  bit            p_we  [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_wdata [N];

  // Reference model state.
  logic [DW-1:0] ref_mem [1024];
  int            next_start;
  bit            pv, perr, prd;
  int            powner;
  logic [DW-1:0] pdata;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  int            last_w;
  int            wait_cnt [N];

  logic [N-1:0]  obs_gnt, obs_rvalid, obs_err;
  logic [DW-1:0] obs_rdata;

  task automatic set_port(input int p, input bit r, input bit w, input int a, input logic [DW-1:0] d);
    p_req[p]   = r;
    p_we[p]    = w;
    p_addr[p]  = AW'(a);
    p_wdata[p] = d;
  endtask

  task automatic clear_ports();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic apply();
    for (int p = 0; p < N; p++) begin
      req[p]             = p_req[p];
      we[p]              = p_we[p];
      addr[p*AW +: AW]   = p_addr[p];
      wdata[p*DW +: DW]  = p_wdata[p];
    end
  endtask

  task automatic model_reset();
    next_start = 0;
    pv         = 1'b0;
    perr       = 1'b0;
    prd        = 1'b0;
    powner     = 0;
    hold_addr  = '0;
    hold_wdata = '0;
    last_w     = -1;
    for (int p = 0; p < N; p++) wait_cnt[p] = 0;
  endtask

  // One clock: check outputs mid-cycle against the model, then commit the model at the edge.
  task automatic step();
    int           w;
    int           p;
    logic [N-1:0] e_gnt, e_rv, e_err;
    @(negedge clock);
    w = -1;
    for (int k = 0; k < N; k++) begin
      p = (next_start + k) % N;
      if (w < 0 && p_req[p]) w = p;
    end
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    check_val("gnt", gnt, e_gnt);
    if (w >= 0) begin
      check_val("mem_addr", mem_addr, p_addr[w]);
      check_val("mem_wdata", mem_wdata, p_wdata[w]);
      check_val("mem_write", mem_write, p_we[w] && (p_addr[w] < DEPTH));
    end else begin
      check_val("mem_addr_hold", mem_addr, hold_addr);
      check_val("mem_wdata_hold", mem_wdata, hold_wdata);
      check_val("mem_write_idle", mem_write, 1'b0);
    end
    e_rv  = '0;
    e_err = '0;
    if (pv && perr)     e_err[powner] = 1'b1;
    else if (pv && prd) e_rv[powner]  = 1'b1;
    check_val("rvalid", rvalid, e_rv);
    check_val("err", err, e_err);
    if (pv && (perr || prd)) check_val("rdata", rdata, perr ? '0 : pdata);
    for (int q = 0; q < N; q++) begin
      if (p_req[q] && !gnt[q]) begin
        wait_cnt[q]++;
        check_val("fair_wait", wait_cnt[q] > N - 1, 1'b0);
      end else begin
        wait_cnt[q] = 0;
      end
    end
    obs_gnt    = gnt;
    obs_rvalid = rvalid;
    obs_err    = err;
    obs_rdata  = rdata;
    @(posedge clock);
    #1;
    last_w = w;
    if (w >= 0) begin
      pv     = 1'b1;
      powner = w;
      perr   = (p_addr[w] >= DEPTH);
      prd    = !p_we[w];
      pdata  = ref_mem[p_addr[w]];
      if (p_we[w] && !perr) ref_mem[p_addr[w]] = p_wdata[w];
      hold_addr  = p_addr[w];
      hold_wdata = p_wdata[w];
      next_start = (w + 1) % N;
    end else begin
      pv = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check_val({tag, "_gnt"}, gnt, '0);
    check_val({tag, "_rvalid"}, rvalid, '0);
    check_val({tag, "_err"}, err, '0);
    check_val({tag, "_rdata"}, rdata, '0);
    check_val({tag, "_mem_write"}, mem_write, 1'b0);
    check_val({tag, "_mem_addr"}, mem_addr, '0);
    check_val({tag, "_mem_wdata"}, mem_wdata, '0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    for (int i = 1; i <= 3; i++) begin
      ram[i]     = 32'h11 * i;
      ref_mem[i] = 32'h11 * i;
    end
    // Requests present during reset must not produce grants.
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b1, 5, 32'h1234);
    apply();
    #1;
    do_reset("rst");
    clear_ports();
    apply();

    // Write then read-back of the same word from a different port.
    set_port(1, 1'b1, 1'b1, 5, 32'hDEADBEEF);
    apply();
    step();
    check_val("raw_gnt_w", obs_gnt, 3'b010);
    set_port(1, 1'b0, 1'b0, 0, '0);
    set_port(0, 1'b1, 1'b0, 5, '0);
    apply();
    step();
    check_val("raw_gnt_r", obs_gnt, 3'b001);
    clear_ports();
    apply();
    step();
    check_val("raw_rvalid", obs_rvalid, 3'b001);
    check_val("raw_rdata", obs_rdata, 32'hDEADBEEF);

    // All three requesting: order 0,1,2,0,1,2 from reset.
    do_reset("rst2");
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 10 + p, '0);
    apply();
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("rr_order", obs_gnt, 64'(1 << (i % 3)));
    end
    clear_ports();
    apply();
    step();

    // Out-of-range read and write.
    set_port(2, 1'b1, 1'b0, 600, '0);
    apply();
    step();
    check_val("oor_gnt2", obs_gnt, 3'b100);
    clear_ports();
    set_port(1, 1'b1, 1'b1, 512, 32'hCAFEF00D);
    apply();
    step();
    check_val("oor_err2", obs_err, 3'b100);
    check_val("oor_rdata2", obs_rdata, '0);
    clear_ports();
    apply();
    step();
    check_val("oor_err1", obs_err, 3'b010);

    // Back-to-back reads of preloaded words 1,2,3.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_port(0, 1'b1, 1'b0, i + 1, '0);
      else       set_port(0, 1'b0, 1'b0, 0, '0);
      apply();
      step();
      if (i > 0) begin
        check_val("b2b_rvalid", obs_rvalid, 3'b001);
        check_val("b2b_rdata", obs_rdata, 32'h11 * i);
      end
    end

    // Reset while a read completion is pending.
    set_port(1, 1'b1, 1'b0, 7, '0);
    apply();
    step();
    clear_ports();
    apply();
    do_reset("midrst");
    step();
    check_val("midrst_no_rvalid", obs_rvalid, '0);
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 30 + p, '0);
    apply();
    step();
    check_val("midrst_first_gnt", obs_gnt, 3'b001);
    clear_ports();
    apply();
    step();

    // Lone requester, then a second one joins.
    set_port(0, 1'b1, 1'b0, 20, '0);
    apply();
    step();
    check_val("join_solo", obs_gnt, 3'b001);
    set_port(0, 1'b1, 1'b0, 21, '0);
    set_port(2, 1'b1, 1'b1, 22, 32'h5A5A_0022);
    apply();
    step();
    check_val("join_p2", obs_gnt, 3'b100);
    set_port(2, 1'b0, 1'b0, 0, '0);
    apply();
    step();
    check_val("join_p0_held", obs_gnt, 3'b001);
    clear_ports();
    apply();
    step();

    // Randomised traffic: new request only when idle or just granted, otherwise hold.
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!p_req[p] || last_w == p) begin
          r = $urandom_range(0, 9);
          if (r < 3) begin
            set_port(p, 1'b0, 1'b0, 0, '0);
          end else if (r < 8) begin
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
          end else if (r < 9) begin
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(512, 1023), $urandom);
          end else begin
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom);
          end
        end
      end
      apply();
      step();
    end
    clear_ports();
    apply();
    step();

    // Final memory image must match the model, including untouched out-of-range words.
    for (int i = 0; i < 1024; i++) check_val("mem_image", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 32-bit word memory between three requesters: instruction fetch (port 0), data load/store (port 1) and disk/IO transfer engine (port 2).
- Round-robin grants at most one access per clock. Drives the memory address, write data and write enable; routes one-cycle-latency read data back to the owner.
- Flags out-of-range addresses.
- Sits between the processor core/disk engine and the memory block.

Parameters:
- ADDR_W, 10, memory address width in bits.
- DATA_W, 32, word width.
- DEPTH, 512, number of implemented words; addresses >= DEPTH are out of range.
- NREQ, 3, number of requesters (fixed at 3 for this revision).

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-port access request, level.
- we  in  NREQ  per-port write enable (1 = write, 0 = read).
- addr  in  NREQ*ADDR_W  per-port word address, port i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  NREQ*DATA_W  per-port write data, same packing.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the access.
- rvalid  out  NREQ  one-hot read-data-valid pulse.
- err  out  NREQ  one-hot out-of-range pulse.
- rdata  out  DATA_W  read data, meaningful only when any rvalid bit is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_write  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after address presented.

Behaviour:
- Reset (async, reset_n=0):
  - rr_ptr=0, pend_valid=0, pend_owner=0, pend_err=0.
  - gnt=0, rvalid=0, err=0, rdata=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Selection, cycle N:
  - Search req starting at index (last_granted+1) mod 3, wrapping; the first asserted port wins. After reset the search starts at port 0.
  - No req asserted: gnt=0, mem_write=0; mem_addr/mem_wdata hold their previous values; rr_ptr unchanged.
- Grant, cycle N:
  - gnt[w]=1; mem_addr=addr[w]; mem_wdata=wdata[w].
  - mem_write = we[w] AND (addr[w] < DEPTH).
  - At the rising edge ending cycle N: the access is committed, rr_ptr <= w, pend_valid <= 1, pend_owner <= w, pend_err <= (addr[w] >= DEPTH), pend_rd <= ~we[w].
- Requester rule: hold req/we/addr/wdata stable while req=1 and gnt=0. The access completes at the edge where gnt=1. Keeping req high afterwards starts a new request.
- Completion, cycle N+1:
  - Read in range: rvalid[pend_owner]=1, rdata=mem_rdata.
  - Out of range (read or write): err[pend_owner]=1, rvalid=0, rdata=0, memory untouched.
  - In-range write: no rvalid and no err.
- Throughput: back-to-back grants every cycle. Grant in N+1 overlaps completion of the N access; the two are independent.
- Fairness: a continuously asserted requester is granted within NREQ cycles.
- Read-after-write, same address: write granted N, read granted N+1 returns the new data.
- Reset asserted mid-operation: a pending rvalid/err is discarded and never emitted.
- Widths: address compare is unsigned ADDR_W bits; DEPTH <= 2**ADDR_W.

Decomposition:
- Shared package holds:
  - Requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_DISK=2.
  - Default ADDR_W/DATA_W/DEPTH.
  - One-hot grant type.
- Sub-module: rr_pick, a combinational 3-way round-robin picker. Inputs req[2:0] and last[1:0]; outputs gnt_onehot[2:0], win[1:0], any.
- Pending-completion register and muxing live in mem_arbiter.

Test Plan:
- Reset, then port 1 write addr=5 data=0xDEADBEEF, then port 0 read addr=5 -> gnt[1] in cycle 1 with mem_write=1; gnt[0] next cycle; rvalid[0] one cycle later with rdata=0xDEADBEEF.
- All three req held high for 6 cycles -> grant order 0,1,2,0,1,2; one-hot gnt every cycle.
- Port 2 read addr=600 -> gnt[2]=1 and mem_write=0; next cycle err[2]=1, rvalid=0, rdata=0. Port 1 write addr=512 -> err[1], memory unchanged.
- Port 0 reads addr 1,2,3 back-to-back (memory preloaded 0x11, 0x22, 0x33) -> rvalid[0] on three consecutive cycles with rdata 0x11, 0x22, 0x33.
- Port 1 read granted, reset_n pulsed low in the following cycle -> no rvalid emitted; all outputs 0; next grant goes to port 0 first.
- Port 0 req with no competitor, then port 2 joins -> port 2 granted no later than the second cycle after joining; port 0's addr held stable while waiting.
